delay3: RTL and testbench
=========================

# delay3

Parametrised, runtime-programmable delay line; successor to the fixed-depth shift-register delay. Delays a W-bit data word plus a valid tag by N clock-enabled cycles, N selectable at run time from 1 to DMAX. Storage is a RAM-style ring buffer rather than a flop chain. It sits in datapath alignment points where a stream must be re-timed against a sibling path whose latency is only known after configuration.

## Interface
- DMAX, 16, maximum delay in ce-cycles; power of two, 2..256
- W, 8, data width in bits
- LW, log2(DMAX)+1 (derived localparam), width of delay select
- i_clk  in  1  clock, all logic on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_ce  in  1  clock enable; buffer advances only when 1
- i_delay  in  LW  requested delay N (clamped, see Operation)
- i_in  in  W  data word
- i_valid  in  1  valid tag for i_in
- o_out  out  W  delayed data word (registered)
- o_valid  out  1  delayed valid tag, qualified by fill state
- o_filled  out  1  buffer holds at least N samples since last flush

## Operation
- Clamp: n_eff = 1 if i_delay==0; DMAX if i_delay>DMAX; else i_delay.
- Registered delay del_q. Reset loads del_q <= clamp(i_delay), wp <= 0, fill <= 0, o_out <= 0, o_valid <= 0, o_filled <= 0. Reset overrides every other event.
- Flush: at any edge (ce irrelevant) where clamp(i_delay) != del_q: del_q <= clamp(i_delay), fill <= 0, o_valid <= 0, o_filled <= 0, o_out holds, wp holds, no push even if i_ce=1.
- Push (i_ce=1, no flush, no reset):
  - mem[wp] <= {i_valid, i_in}; wp <= wp+1 mod DMAX.
  - Output: if del_q==1, {o_valid_raw, o_out} <= {i_valid, i_in}; else <= mem[(wp-(del_q-1)) mod DMAX].
  - fill <= min(fill+1, del_q).
  - o_valid <= o_valid_raw AND (fill+1 >= del_q); o_filled <= (fill+1 >= del_q).
- Hold (i_ce=0, no flush): all state and outputs unchanged.
- Stale RAM contents after reset/flush never reach o_valid=1; o_out may show stale data while o_valid=0.
- Memory has no reset; implementation must not rely on its contents.

## Timing
- Latency: sample pushed at ce-edge k appears on o_out/o_valid after ce-edge k+N-1 (N=1: one register stage, visible after the capturing edge). Counted in ce-edges, not clocks.
- After reset or flush with continuous ce: o_filled and first o_valid=1 (if input valid) rise after the N-th push edge.
- N=DMAX: read address equals wp+1 mod DMAX (oldest entry); wp wraps DMAX-1 -> 0 with no bubble.
- i_delay changes are seen on the same edge; a change lasting one cycle causes two flushes (change and change back).
- Simultaneous flush and ce: flush wins, the sample on i_in is dropped.
- Throughput: one sample per ce-edge, no back-pressure.

## Test plan
- Reset, i_delay=3, ce=1, i_valid=1, i_in sequence 1,5,2,3,0 on consecutive edges -> o_out 1,5,2,3,0 appearing after push edges 3..7; o_valid/o_filled rise after edge 3, 0 before.
- i_delay=4, ce toggling 1,0,1,0...: i_in 0x11 at first ce-edge appears on o_out only after the 4th ce-edge (7th clock); outputs frozen on ce=0 clocks.
- Steady stream at N=2, switch i_delay to 5 mid-stream -> same edge o_valid=0, o_filled=0, o_out held; sample pushed at next edge emerges 5 ce-edges later with o_valid=1.
- i_delay=0 -> behaves as N=1 (o_out follows i_in one edge later); i_delay=31 with DMAX=16 -> behaves as N=16.
- DMAX=16, N=16, 40 ce-edges of counter data 0x00..0x27 -> o_out = counter-15 from edge 16 onward, continuous across wp wrap, o_valid tracks injected i_valid=0 at sample 0x14.
- Reset asserted mid-stream (N=3, buffer full) for one edge -> next cycle o_out=0, o_valid=0, o_filled=0; pre-reset samples never reappear with o_valid=1.

Source files
------------

// File: rtl/delay3.sv
// delay3
//   Runtime-programmable delay line. A W-bit data word and its valid tag are
//   delayed by N clock-enabled cycles, with N chosen at run time in 1..DMAX.
//   Samples are stored in a ring buffer indexed by a write pointer rather
//   than in a flop chain, so the delay can change without moving data.
//
// Parameters
//   DMAX  maximum delay in ce-cycles (power of two, 2..256)
//   W     data width in bits
//   LW    width of the delay select, log2(DMAX)+1 (derived)
//
// Ports
//   i_clk     clock, all logic on the rising edge
//   i_reset   synchronous active-high reset
//   i_ce      clock enable; the buffer only advances when high
//   i_delay   requested delay N, clamped to 1..DMAX
//   i_in      data word
//   i_valid   valid tag for i_in
//   o_out     delayed data word (registered)
//   o_valid   delayed valid tag, forced low until the buffer has filled
//   o_filled  buffer holds at least N samples since the last flush
module delay3 #(
  parameter int DMAX = 16,
  parameter int W = 8,
  localparam int LW = $clog2(DMAX) + 1
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_ce,
  input  logic [LW-1:0] i_delay,
  input  logic [W-1:0]  i_in,
  input  logic          i_valid,
  output logic [W-1:0]  o_out,
  output logic          o_valid,
  output logic          o_filled
);

  localparam int AW = $clog2(DMAX);

  // A zero request means "no delay", which the line cannot do, so it becomes
  // one stage; requests beyond the buffer depth saturate at the depth.
  function automatic logic [LW-1:0] clamp_delay(input logic [LW-1:0] d);
    if (d == '0) begin
      return LW'(1);
    end else if (d > LW'(DMAX)) begin
      return LW'(DMAX);
    end else begin
      return d;
    end
  endfunction

  logic [W:0]    mem [DMAX];
  logic [LW-1:0] del_q;
  logic [LW-1:0] fill;
  logic [AW-1:0] wp;

  logic [LW-1:0] n_eff;
  logic          flush;
  logic          push;
  logic [AW-1:0] rd_addr;
  logic [W:0]    src_word;
  logic          reach;

  // The read address trails the write pointer by N-1 entries, so the word
  // leaving the buffer on a push is the one written N-1 pushes earlier; the
  // output register adds the last stage. With N=DMAX this lands on wp+1,
  // the oldest entry, which is never the slot being written on the same
  // edge. N=1 bypasses the RAM entirely.
  always_comb begin
    n_eff    = clamp_delay(i_delay);
    flush    = (n_eff != del_q);
    push     = i_ce && !flush;
    rd_addr  = wp - AW'(del_q - LW'(1));
    src_word = (del_q == LW'(1)) ? {i_valid, i_in} : mem[rd_addr];
    reach    = (fill + LW'(1)) >= del_q;
  end

  // Storage has no reset: whatever it holds after reset or a flush is kept
  // out of o_valid by the fill counter, so clearing it buys nothing.
  always_ff @(posedge i_clk) begin
    if (!i_reset && push) begin
      mem[wp] <= {i_valid, i_in};
    end
  end

  // Control and output registers. A change of the clamped delay flushes the
  // line on the same edge and wins over a simultaneous push, dropping the
  // sample on i_in; o_out is left alone so the datapath does not glitch.
  // fill saturates at the current delay and gates the valid tag, which is
  // how stale RAM contents are kept from surfacing as valid data.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      del_q    <= n_eff;
      wp       <= '0;
      fill     <= '0;
      o_out    <= '0;
      o_valid  <= 1'b0;
      o_filled <= 1'b0;
    end else if (flush) begin
      del_q    <= n_eff;
      fill     <= '0;
      o_valid  <= 1'b0;
      o_filled <= 1'b0;
    end else if (i_ce) begin
      wp       <= wp + AW'(1);
      fill     <= reach ? del_q : fill + LW'(1);
      o_out    <= src_word[W-1:0];
      o_valid  <= src_word[W] && reach;
      o_filled <= reach;
    end
  end

endmodule

// File: tb/tb_delay3.sv
// tb_delay3
//   Directed test of delay3 at DMAX=16, W=8. Each vector drives one clock
//   edge and compares the packed output {o_filled, o_valid, o_out} (or a
//   slice of it) against a hand-derived value.
module tb_delay3;

  logic       i_clk;
  logic       i_reset;
  logic       i_ce;
  logic [4:0] i_delay;
  logic [7:0] i_in;
  logic       i_valid;
  logic [7:0] o_out;
  logic       o_valid;
  logic       o_filled;

  int vectorCount = 0;
  int missCount = 0;

  delay3 #(.DMAX(16), .W(8)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_ce    (i_ce),
    .i_delay (i_delay),
    .i_in    (i_in),
    .i_valid (i_valid),
    .o_out   (o_out),
    .o_valid (o_valid),
    .o_filled(o_filled)
  );

  // Free-running 10-unit clock.
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Drive one set of inputs across a rising edge, then settle past it so the
  // outputs are sampled well away from the edge.
  task automatic applyStimulus(input logic rst, input logic ce, input logic [4:0] dly,
                               input logic vld, input logic [7:0] din);
    i_reset = rst;
    i_ce    = ce;
    i_delay = dly;
    i_valid = vld;
    i_in    = din;
    @(posedge i_clk);
    #1;
  endtask

  // Count one comparison and report it if the observed value is wrong.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectorCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {22'd0, o_filled, o_valid, o_out};
  endfunction

  function automatic logic [31:0] flags();
    return {30'd0, o_filled, o_valid};
  endfunction

  logic [7:0] seqIn  [5] = '{8'h02, 8'h03, 8'h00, 8'h09, 8'h09};
  logic [7:0] seqOut [5] = '{8'h01, 8'h05, 8'h02, 8'h03, 8'h00};

  initial begin
    i_reset = 1'b1;
    i_ce    = 1'b0;
    i_delay = 5'd3;
    i_in    = 8'h00;
    i_valid = 1'b0;

    // Reset at N=3, then a stream 1,5,2,3,0 that emerges after edges 3..7.
    applyStimulus(1'b1, 1'b0, 5'd3, 1'b0, 8'h00);
    checkOutput("reset", outs(), 32'h000);
    applyStimulus(1'b0, 1'b1, 5'd3, 1'b1, 8'h01);
    checkOutput("n3_edge1_flags", flags(), 32'h0);
    applyStimulus(1'b0, 1'b1, 5'd3, 1'b1, 8'h05);
    checkOutput("n3_edge2_flags", flags(), 32'h0);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 1'b1, 5'd3, 1'b1, seqIn[k]);
      checkOutput($sformatf("n3_edge%0d", k + 3), outs(), {22'd0, 2'b11, seqOut[k]});
    end

    // Reset with a full buffer: everything clears and old data stays hidden.
    applyStimulus(1'b1, 1'b1, 5'd3, 1'b1, 8'hAA);
    checkOutput("reset_mid", outs(), 32'h000);
    applyStimulus(1'b0, 1'b1, 5'd3, 1'b1, 8'h40);
    checkOutput("post_reset_e1", flags(), 32'h0);
    applyStimulus(1'b0, 1'b1, 5'd3, 1'b1, 8'h41);
    checkOutput("post_reset_e2", flags(), 32'h0);
    applyStimulus(1'b0, 1'b1, 5'd3, 1'b1, 8'h42);
    checkOutput("post_reset_e3", outs(), 32'h340);

    // N=4 with ce toggling: 0x11 surfaces only on the 4th ce-edge (7th clock).
    applyStimulus(1'b1, 1'b0, 5'd4, 1'b0, 8'h00);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, (i % 2) == 0, 5'd4, 1'b1, 8'(8'h11 * (i / 2 + 1)));
    end
    checkOutput("ce_n4_pre", flags(), 32'h0);
    applyStimulus(1'b0, 1'b1, 5'd4, 1'b1, 8'h44);
    checkOutput("ce_n4_first", outs(), 32'h311);
    applyStimulus(1'b0, 1'b0, 5'd4, 1'b1, 8'h99);
    checkOutput("ce_n4_hold", outs(), 32'h311);
    applyStimulus(1'b0, 1'b1, 5'd4, 1'b1, 8'h55);
    checkOutput("ce_n4_next", outs(), 32'h322);

    // Switch to N=2: flush edge drops its sample and holds o_out.
    applyStimulus(1'b0, 1'b1, 5'd2, 1'b1, 8'hEE);
    checkOutput("flush_n2", outs(), 32'h022);
    applyStimulus(1'b0, 1'b1, 5'd2, 1'b1, 8'hA0);
    checkOutput("n2_e1_flags", flags(), 32'h0);
    applyStimulus(1'b0, 1'b1, 5'd2, 1'b1, 8'hA1);
    checkOutput("n2_e2", outs(), 32'h3A0);
    applyStimulus(1'b0, 1'b1, 5'd2, 1'b1, 8'hA2);
    checkOutput("n2_e3", outs(), 32'h3A1);
    applyStimulus(1'b0, 1'b1, 5'd2, 1'b1, 8'hA3);
    checkOutput("n2_e4", outs(), 32'h3A2);

    // Mid-stream switch to N=5: first new sample emerges 5 ce-edges later.
    applyStimulus(1'b0, 1'b1, 5'd5, 1'b1, 8'hEE);
    checkOutput("flush_n5", outs(), 32'h0A2);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 1'b1, 5'd5, 1'b1, 8'(8'hB0 + k));
    end
    checkOutput("n5_e4_flags", flags(), 32'h0);
    applyStimulus(1'b0, 1'b1, 5'd5, 1'b1, 8'hB4);
    checkOutput("n5_e5", outs(), 32'h3B0);

    // i_delay=0 clamps to N=1: o_out follows i_in one edge later.
    applyStimulus(1'b0, 1'b1, 5'd0, 1'b1, 8'hEE);
    checkOutput("flush_n1", outs(), 32'h0B0);
    applyStimulus(1'b0, 1'b1, 5'd0, 1'b1, 8'hC0);
    checkOutput("n1_valid", outs(), 32'h3C0);
    applyStimulus(1'b0, 1'b1, 5'd0, 1'b0, 8'hC1);
    checkOutput("n1_invalid", outs(), 32'h2C1);

    // i_delay=31 clamps to N=16: counter stream across the pointer wrap,
    // with a single invalid sample at 0x14.
    applyStimulus(1'b0, 1'b1, 5'd31, 1'b1, 8'hEE);
    checkOutput("flush_n16", outs(), 32'h0C1);
    for (int e = 1; e <= 40; e++) begin
      applyStimulus(1'b0, 1'b1, 5'd31, (e - 1) != 8'h14, 8'(e - 1));
      if (e < 16) begin
        checkOutput($sformatf("n16_fill_e%0d", e), flags(), 32'h0);
      end else begin
        checkOutput($sformatf("n16_e%0d", e), outs(),
                    {22'd0, 1'b1, (e - 16) != 8'h14, 8'(e - 16)});
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
